perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NumCh, default 8, number of event channels (legal 2..16).
REQ-002 Parameter CntBit, default 32, width of each counter (legal 8..32).
REQ-003 Parameter SatMode, default 0, overflow policy: 0 = wrap, 1 = saturate.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; ports named clk and rst.
REQ-005 clk  input  1  core clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  global count enable (core running); gates increments only.
REQ-008 evt  input  NumCh  per-channel event strobes, one increment per high cycle.
REQ-009 clr  input  1  clears all live counters and overflow flags.
REQ-010 snap  input  1  copies all live counters into shadow registers.
REQ-011 sel  input  clog2(NumCh)  channel select for random readout.
REQ-012 rd_shadow  input  1  readout source: 0 = live, 1 = shadow.
REQ-013 rd_data  output  CntBit  selected counter value, registered.
REQ-014 ovf  output  NumCh  sticky per-channel overflow flags.
REQ-015 dump_start  input  1  starts a serial dump of all shadow registers.
REQ-016 dump_ready  input  1  consumer accepts the current dump beat.
REQ-017 dump_valid  output  1  dump beat valid.
REQ-018 dump_data  output  CntBit  shadow value of channel dump_idx.
REQ-019 dump_idx  output  clog2(NumCh)  channel index of the current beat.
REQ-020 dump_last  output  1  high on the final beat (dump_idx = NumCh-1).
REQ-021 busy  output  1  high while the dump FSM is not IDLE.

Function
REQ-022 Live counter i SHALL increment by 1 each cycle en && evt[i], with no other effect.
REQ-023 At all-ones with an increment: SatMode=0 -> 0; SatMode=1 -> holds all-ones; both set ovf[i].
REQ-024 clr SHALL zero all live counters and ovf next cycle; clr beats a same-cycle increment; shadows are untouched.
REQ-025 snap SHALL capture pre-increment live values; the same-cycle increment still lands in live; clr+snap captures pre-clear values.
REQ-026 snap SHALL be ignored while busy; clr and counting continue during a dump.
REQ-027 rd_data SHALL show the live or shadow value selected by sel and rd_shadow, 1-cycle latency; sel >= NumCh returns 0.
REQ-028 Dump FSM states IDLE, DUMP. IDLE->DUMP on dump_start, dump_idx=0. A DUMP beat transfers when dump_valid && dump_ready; then dump_idx increments or, if dump_last, goes IDLE.
REQ-029 In DUMP, dump_valid=1 and dump_data/dump_idx/dump_last SHALL stay stable until a transfer; dump_start is ignored.
REQ-030 In IDLE, dump_valid=0 and dump_last=0; dump_start and dump_ready high together start a dump and transfer beat 0 one cycle later at the earliest.
REQ-031 en low SHALL freeze counting only; snap, clr, readout and dump operate normally.

Reset
REQ-032 rst SHALL force live counters, shadows, ovf, rd_data, dump_data, dump_idx to 0; FSM to IDLE; dump_valid, dump_last, busy to 0.
REQ-033 rst SHALL win over every other input, including mid-dump; dump_valid is 0 in the cycle after rst.

Structure
REQ-034 The SatMode encodings (WRAP, SAT) and FSM state encodings SHALL be constants in the shared header next to the existing MUX_DISP_DATA defines.
REQ-035 One sub-module perf_counter_channel (live counter, shadow, ovf, SatMode) SHALL be instantiated NumCh times.
REQ-036 Readout mux and dump FSM SHALL live in perf_counter_bank.

Verification (NumCh=4, CntBit=8)
REQ-037 rst, en=1, 5 pulses on evt[0], sel=0, rd_shadow=0 -> rd_data=5 one cycle after the last pulse; ovf=0.
REQ-038 SatMode=0, 256 pulses on evt[1] -> live=0, ovf[1]=1. SatMode=1, 300 pulses -> live=255, ovf[1]=1.
REQ-039 Live ch2=10; snap and evt[2] in one cycle -> shadow=10, live=11. clr and evt[2] in one cycle -> live=0, ovf=0.
REQ-040 Shadows 7,8,9,10, dump_start, dump_ready pattern 1,0,1,1,0,1 -> 4 beats: idx 0..3, data 7..10, stable while ready=0, dump_last only on idx 3, then IDLE.
REQ-041 rst during DUMP at idx 2 -> next cycle dump_valid=0, busy=0, all counters 0; a later dump_start restarts at idx 0.
REQ-042 en=0 with evt=4'b1111 for 10 cycles -> counts unchanged; snap still updates shadows.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// rtl/perf_counter_bank_pkg.sv - shared constants for the performance counter bank
//
// Purpose: overflow-policy encodings and dump FSM state encodings shared by
//          perf_counter_bank and perf_counter_channel.
// Ports:   none (package).
package perf_counter_bank_pkg;

    // Overflow policy selected by the SatMode parameter.
    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    // Dump FSM state encodings.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DUMP = 1'b1;

endpackage

// File: rtl/perf_counter_channel.sv
// rtl/perf_counter_channel.sv - one event channel: live counter, shadow copy, sticky overflow
//
// Purpose: counts single-cycle increments with wrap or saturate policy,
//          captures the live value into a shadow register on snap.
// Ports:
//   clk, rst  - core clock, synchronous active-high reset
//   i_inc     - increment this cycle (already qualified by the global enable)
//   i_clr     - zero live counter and overflow flag
//   i_snap    - copy the pre-update live value into the shadow
//   o_live    - live counter value
//   o_shadow  - shadow counter value
//   o_ovf     - sticky overflow flag
module perf_counter_channel
    import perf_counter_bank_pkg::*;
#(
    parameter int CntBit  = 32,
    parameter int SatMode = SAT_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              i_snap,
    output logic [CntBit-1:0] o_live,
    output logic [CntBit-1:0] o_shadow,
    output logic              o_ovf
);

    logic [CntBit-1:0] r_live;
    logic [CntBit-1:0] r_shadow;
    logic              r_ovf;
    logic              w_all_ones;

    assign w_all_ones = &r_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live   <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // Shadow takes the value before this cycle's increment or clear.
            if (i_snap) begin
                r_shadow <= r_live;
            end
            if (i_clr) begin
                r_live <= '0;
                r_ovf  <= 1'b0;
            end else if (i_inc) begin
                if (w_all_ones) begin
                    r_ovf <= 1'b1;
                    if (SatMode == SAT_SAT) begin
                        r_live <= r_live;
                    end else begin
                        r_live <= '0;
                    end
                end else begin
                    r_live <= r_live + 1'b1;
                end
            end
        end
    end

    assign o_live   = r_live;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with snapshot, random readout and serial dump
//
// Purpose: NumCh event counters with shadow snapshot, registered random
//          readout of live/shadow values and a ready/valid dump of all shadows.
// Ports:
//   clk, rst                 - core clock, synchronous active-high reset
//   en, evt                  - global count enable, per-channel event strobes
//   clr, snap                - clear live counters/ovf, snapshot live into shadows
//   sel, rd_shadow, rd_data  - readout select, source select, registered readout
//   ovf                      - sticky per-channel overflow flags
//   dump_start, dump_ready   - dump request, consumer accept
//   dump_valid, dump_data,
//   dump_idx, dump_last      - dump beat outputs
//   busy                     - dump in progress
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int NumCh   = 8,
    parameter int CntBit  = 32,
    parameter int SatMode = SAT_WRAP,
    localparam int SelW   = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NumCh-1:0]  evt,
    input  logic              clr,
    input  logic              snap,
    input  logic [SelW-1:0]   sel,
    input  logic              rd_shadow,
    output logic [CntBit-1:0] rd_data,
    output logic [NumCh-1:0]  ovf,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [CntBit-1:0] dump_data,
    output logic [SelW-1:0]   dump_idx,
    output logic              dump_last,
    output logic              busy
);

    localparam logic [SelW:0]   NUM_CH_W = (SelW + 1)'(NumCh);
    localparam logic [SelW-1:0] LAST_IDX = SelW'(NumCh - 1);

    logic [CntBit-1:0] w_live   [NumCh];
    logic [CntBit-1:0] w_shadow [NumCh];
    logic [NumCh-1:0]  w_ovf;
    logic              w_snap;
    logic              w_dumping;
    logic              w_last;
    logic [CntBit-1:0] w_rd_mux;

    logic [0:0]        r_state;
    logic [SelW-1:0]   r_dump_idx;
    logic [CntBit-1:0] r_rd_data;

    // Shadows must not change under an in-flight dump.
    assign w_snap    = snap && !w_dumping;
    assign w_dumping = (r_state == ST_DUMP);
    assign w_last    = w_dumping && (r_dump_idx == LAST_IDX);

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        perf_counter_channel #(
            .CntBit  (CntBit),
            .SatMode (SatMode)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (en && evt[g]),
            .i_clr    (clr),
            .i_snap   (w_snap),
            .o_live   (w_live[g]),
            .o_shadow (w_shadow[g]),
            .o_ovf    (w_ovf[g])
        );
    end

    // Out-of-range selects (non power-of-two NumCh) read as zero.
    always_comb begin
        w_rd_mux = '0;
        if ({1'b0, sel} < NUM_CH_W) begin
            w_rd_mux = rd_shadow ? w_shadow[sel] : w_live[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dump_idx <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
            case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        r_state    <= ST_DUMP;
                        r_dump_idx <= '0;
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (w_last) begin
                            r_state    <= ST_IDLE;
                            r_dump_idx <= '0;
                        end else begin
                            r_dump_idx <= r_dump_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dump_idx <= '0;
                end
            endcase
        end
    end

    assign rd_data    = r_rd_data;
    assign ovf        = w_ovf;
    assign dump_valid = w_dumping;
    assign dump_idx   = r_dump_idx;
    assign dump_last  = w_last;
    // Shadows are frozen while dumping, so a direct mux stays stable per beat.
    assign dump_data  = w_shadow[r_dump_idx];
    assign busy       = w_dumping;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank (wrap and saturate instances)
module tb_perf_counter_bank;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] rd0;
        logic [W-1:0] rd1;
        logic [N-1:0] ovf0;
        logic [N-1:0] ovf1;
        logic         busy;
        logic         valid;
        logic         last;
        logic [1:0]   idx;
    } exp_t;

    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [N-1:0] evt = '0;
    logic         clr = 1'b0;
    logic         snap = 1'b0;
    logic [1:0]   sel = '0;
    logic         rd_shadow = 1'b0;
    logic         dump_start = 1'b0;
    logic         dump_ready = 1'b0;

    logic [W-1:0] rd_data_w, rd_data_s, dump_data_w, dump_data_s;
    logic [N-1:0] ovf_w, ovf_s;
    logic [1:0]   dump_idx_w, dump_idx_s;
    logic         dump_valid_w, dump_valid_s, dump_last_w, dump_last_s, busy_w, busy_s;

    int n_checks = 0;
    int n_errors = 0;

    exp_t  exp_q[$];
    beat_t beat_q[$];

    // Reference state: index 0 = wrapping instance, 1 = saturating instance.
    int         m_live [2][N];
    int         m_sh   [2][N];
    bit [N-1:0] m_ovf  [2];
    bit         m_dump;
    int         m_pos;

    always #5 clk = ~clk;

    perf_counter_bank #(.NumCh(N), .CntBit(W), .SatMode(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
        .sel(sel), .rd_shadow(rd_shadow), .rd_data(rd_data_w), .ovf(ovf_w),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid_w),
        .dump_data(dump_data_w), .dump_idx(dump_idx_w), .dump_last(dump_last_w),
        .busy(busy_w)
    );

    perf_counter_bank #(.NumCh(N), .CntBit(W), .SatMode(1)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
        .sel(sel), .rd_shadow(rd_shadow), .rd_data(rd_data_s), .ovf(ovf_s),
        .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid_s),
        .dump_data(dump_data_s), .dump_idx(dump_idx_s), .dump_last(dump_last_s),
        .busy(busy_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Applies the current inputs to the reference model, records what the
    // DUTs must show after the coming rising edge, then waits past that edge.
    task automatic step();
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            int v;
            v = rd_shadow ? m_sh[m][sel] : m_live[m][sel];
            if (m == 0) e.rd0 = rst ? '0 : W'(v);
            else        e.rd1 = rst ? '0 : W'(v);
        end
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    m_live[m][i] = 0;
                    m_sh[m][i]   = 0;
                end
                m_ovf[m] = '0;
            end
            m_dump = 0;
            m_pos  = 0;
            beat_q.delete();
        end else begin
            bit xfer;
            bit was_dump;
            xfer     = m_dump && dump_ready;
            was_dump = m_dump;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) begin
                    if (snap && !was_dump) m_sh[m][i] = m_live[m][i];
                    if (clr) begin
                        m_live[m][i] = 0;
                        m_ovf[m][i]  = 1'b0;
                    end else if (en && evt[i]) begin
                        if (m_live[m][i] == (1 << W) - 1) begin
                            m_ovf[m][i]  = 1'b1;
                            m_live[m][i] = (m == 1) ? (1 << W) - 1 : 0;
                        end else begin
                            m_live[m][i] = m_live[m][i] + 1;
                        end
                    end
                end
            end
            if (!was_dump && dump_start) begin
                m_dump = 1;
                m_pos  = 0;
                for (int i = 0; i < N; i++) begin
                    beat_t b;
                    b.idx = 2'(i);
                    b.d0  = W'(m_sh[0][i]);
                    b.d1  = W'(m_sh[1][i]);
                    beat_q.push_back(b);
                end
            end else if (xfer) begin
                if (m_pos == N - 1) begin
                    m_dump = 0;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        e.ovf0  = m_ovf[0];
        e.ovf1  = m_ovf[1];
        e.busy  = m_dump;
        e.valid = m_dump;
        e.idx   = 2'(m_pos);
        e.last  = m_dump && (m_pos == N - 1);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; en = 1; evt = '0; clr = 0; snap = 0;
        dump_start = 0; dump_ready = 0; rd_shadow = 0; sel = '0;
    endtask

    // Registered-output monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data_wrap", rd_data_w, e.rd0);
                check("rd_data_sat", rd_data_s, e.rd1);
                check("ovf_wrap", ovf_w, e.ovf0);
                check("ovf_sat", ovf_s, e.ovf1);
                check("busy", {busy_w, busy_s}, {e.busy, e.busy});
                check("dump_valid", {dump_valid_w, dump_valid_s}, {e.valid, e.valid});
                check("dump_idx", {dump_idx_w, dump_idx_s}, {e.idx, e.idx});
                check("dump_last", {dump_last_w, dump_last_s}, {e.last, e.last});
            end
        end
    end

    // Dump beat monitor: compares every accepted beat against the queued shadows.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (dump_valid_w && dump_ready && !rst) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_idx", dump_idx_w, b.idx);
                    check("beat_data_wrap", dump_data_w, b.d0);
                    check("beat_data_sat", dump_data_s, b.d1);
                    check("beat_last", dump_last_w, (b.idx == 2'(N - 1)));
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        // Reset state and five pulses on channel 0.
        rst = 1; step();
        step();
        quiet();
        for (int k = 0; k < 5; k++) begin evt = 4'b0001; step(); end
        evt = '0; step();
        check("five_pulses_rd", rd_data_w, 5);
        check("five_pulses_ovf", ovf_w, 0);

        // Wrap vs saturate on channel 1.
        rst = 1; step(); quiet(); sel = 2'd1;
        for (int k = 0; k < 256; k++) begin evt = 4'b0010; step(); end
        evt = '0; step();
        check("wrap256_live", rd_data_w, 0);
        check("wrap256_ovf", ovf_w[1], 1);
        for (int k = 0; k < 44; k++) begin evt = 4'b0010; step(); end
        evt = '0; step();
        check("sat300_live", rd_data_s, 255);
        check("sat300_ovf", ovf_s[1], 1);

        // Snap and clear against a same-cycle increment on channel 2.
        rst = 1; step(); quiet(); sel = 2'd2;
        for (int k = 0; k < 10; k++) begin evt = 4'b0100; step(); end
        snap = 1; step(); snap = 0; evt = '0;
        rd_shadow = 1; step();
        rd_shadow = 0; step();
        check("snap_shadow_live", rd_data_w, 11);
        clr = 1; evt = 4'b0100; step(); clr = 0; evt = '0; step();
        check("clr_live", rd_data_w, 0);

        // Dump of shadows 7..10 with a stalling consumer.
        rst = 1; step(); quiet();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) evt[i] = (c < 7 + i);
            step();
        end
        evt = '0; snap = 1; step(); snap = 0;
        dump_start = 1; step(); dump_start = 0;
        for (int k = 0; k < 6; k++) begin
            dump_ready = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            step();
        end
        dump_ready = 0; step();

        // Reset in the middle of a dump, then restart.
        dump_start = 1; step(); dump_start = 0;
        dump_ready = 1; step(); step();
        rst = 1; step(); rst = 0;
        check("rst_mid_dump_valid", dump_valid_w, 0);
        check("rst_mid_dump_busy", busy_w, 0);
        dump_start = 1; dump_ready = 1; step(); dump_start = 0;
        for (int k = 0; k < 5; k++) step();
        dump_ready = 0;

        // Enable low freezes counting, snap still works.
        for (int k = 0; k < 5; k++) begin evt = 4'b1111; step(); end
        en = 0;
        for (int k = 0; k < 10; k++) begin evt = 4'b1111; step(); end
        snap = 1; step(); snap = 0;
        rd_shadow = 1;
        for (int i = 0; i < N; i++) begin sel = 2'(i); step(); end
        en = 1;

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            rst        = ($urandom_range(63) == 0);
            en         = ($urandom_range(7) != 0);
            evt        = 4'($urandom);
            clr        = ($urandom_range(31) == 0);
            snap       = ($urandom_range(7) == 0);
            sel        = 2'($urandom);
            rd_shadow  = 1'($urandom);
            dump_start = ($urandom_range(7) == 0);
            dump_ready = 1'($urandom);
            step();
        end

        // Drain any in-flight dump.
        quiet(); dump_ready = 1;
        for (int k = 0; k < 8; k++) step();
        @(negedge clk);
        @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("beat_queue_drained", beat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
